// File: rtl/control_ranas_pkg.sv
// Shared definitions for the frog-game round controller: state encodings,
// default start code and the Moore output decode helpers.
package control_ranas_pkg;

    localparam logic [2:0] START_CODE_DEFAULT = 3'b111;

    typedef enum logic [3:0] {
        INICIO   = 4'd0,
        INI_RANA = 4'd1,
        JUGANDO  = 4'd2,
        GANO     = 4'd3,
        PERDIO   = 4'd4
    } state_t;

    // Unused encodings fall through to 0 on every pulse, matching INICIO.
    function automatic logic rana_ini_dec(input state_t s);
        return (s == INI_RANA) || (s == GANO) || (s == PERDIO);
    endfunction

    function automatic logic gano_dec(input state_t s);
        return (s == GANO);
    endfunction

    function automatic logic perdio_dec(input state_t s);
        return (s == PERDIO);
    endfunction

endpackage

// File: rtl/control_ranas_timer.sv
// Per-frog cycle counter: runs while enabled, restarts on clear, and flags
// the last allowed cycle through expire.
module control_ranas_timer #(
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic CR_CLOCK_50,
    input  logic CR_RESET,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CICLOS - 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and checked first.
    always_ff @(posedge CR_CLOCK_50) begin
        if (CR_RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/control_ranas_n.sv
// Round controller for the frog game: places frogs, counts frogs home and
// lives left. Optional per-frog timeout is enabled by macro CR_TIMEOUT_EN.
module control_ranas_n
    import control_ranas_pkg::*;
#(
    parameter int                          DATAWIDTH_ESTADO = 3,
    parameter logic [DATAWIDTH_ESTADO-1:0] START_CODE       = DATAWIDTH_ESTADO'(START_CODE_DEFAULT),
    parameter int                          NUM_RANAS        = 3,
    parameter int                          NUM_VIDAS        = 1,
    parameter int                          TIMEOUT_CICLOS   = 50000000,
    localparam int                         RW               = $clog2(NUM_RANAS + 1),
    localparam int                         VW               = $clog2(NUM_VIDAS + 1)
) (
    input  logic                        CR_CLOCK_50,
    input  logic                        CR_RESET,
    input  logic [DATAWIDTH_ESTADO-1:0] CR_ESTADO,
    input  logic                        CR_GANO,
    input  logic                        CR_PERDIO,
    output logic                        CR_RANA_INI_OUT,
    output logic                        CR_GANO_JC_OUT,
    output logic                        CR_PERDIO_JC_OUT,
    output logic [RW-1:0]               CR_RANAS_OUT,
    output logic [VW-1:0]               CR_VIDAS_OUT,
    output logic                        CR_TIMEOUT_OUT
);

    localparam logic [RW-1:0] RANAS_META = RW'(NUM_RANAS);
    localparam logic [VW-1:0] VIDAS_INI  = VW'(NUM_VIDAS);

    state_t        state;
    logic [RW-1:0] ranas;
    logic [VW-1:0] vidas;
    logic [RW-1:0] ranas_inc;
    logic [VW-1:0] vidas_dec;
    logic          timeout;
    logic          loss;

`ifdef CR_TIMEOUT_EN
    logic expire;

    control_ranas_timer #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_timer (
        .CR_CLOCK_50 (CR_CLOCK_50),
        .CR_RESET    (CR_RESET),
        .clear       (state == INI_RANA),
        .enable      (state == JUGANDO),
        .expire      (expire)
    );

    // A frog reaching home on its last cycle is a win, not a timeout.
    assign timeout = expire && !CR_GANO;
`else
    assign timeout = 1'b0;
`endif

    assign ranas_inc = ranas + RW'(1);
    assign vidas_dec = vidas - VW'(1);
    assign loss      = CR_PERDIO || timeout;

    always_ff @(posedge CR_CLOCK_50) begin
        if (CR_RESET) begin
            state <= INICIO;
            ranas <= '0;
            vidas <= VIDAS_INI;
        end else begin
            case (state)
                INICIO: begin
                    if (CR_ESTADO == START_CODE) begin
                        state <= INI_RANA;
                        ranas <= '0;
                        vidas <= VIDAS_INI;
                    end
                end
                INI_RANA: state <= JUGANDO;
                JUGANDO: begin
                    if (CR_GANO) begin
                        ranas <= ranas_inc;
                        state <= (ranas_inc == RANAS_META) ? GANO : INI_RANA;
                    end else if (loss) begin
                        vidas <= vidas_dec;
                        state <= (vidas_dec == '0) ? PERDIO : INI_RANA;
                    end
                end
                GANO:    state <= INICIO;
                PERDIO:  state <= INICIO;
                default: state <= INICIO;
            endcase
        end
    end

    // Pulses come from the state register alone; counters stay visible in INICIO.
    assign CR_RANA_INI_OUT  = rana_ini_dec(state);
    assign CR_GANO_JC_OUT   = gano_dec(state);
    assign CR_PERDIO_JC_OUT = perdio_dec(state);
    assign CR_RANAS_OUT     = ranas;
    assign CR_VIDAS_OUT     = vidas;
    assign CR_TIMEOUT_OUT   = timeout;

endmodule

// File: tb/tb_control_ranas_n.sv
// Self-checking bench for control_ranas_n: two instances (default lives and
// two lives) driven together, compared every cycle against a game-level model.
module tb_control_ranas_n;

    localparam int TO = 10;
`ifdef CR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Model phases: 0 idle, 1 placing frog, 2 playing, 3 won, 4 lost
    typedef struct packed {
        int ph;
        int ranas;
        int vidas;
        int tmr;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] estado;
    logic       gano;
    logic       perdio;

    logic       a_rana, a_gjc, a_pjc, a_to;
    logic [1:0] a_ranas;
    logic [0:0] a_vidas;
    logic       b_rana, b_gjc, b_pjc, b_to;
    logic [1:0] b_ranas;
    logic [1:0] b_vidas;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    mdl_t m_a, m_b;
    int   c_rana_a, c_gjc_a, c_pjc_a, c_to_a;
    int   c_rana_b, c_pjc_b;

    always #10 clk = ~clk;

    control_ranas_n #(
        .TIMEOUT_CICLOS (TO)
    ) u_a (
        .CR_CLOCK_50      (clk),
        .CR_RESET         (rst),
        .CR_ESTADO        (estado),
        .CR_GANO          (gano),
        .CR_PERDIO        (perdio),
        .CR_RANA_INI_OUT  (a_rana),
        .CR_GANO_JC_OUT   (a_gjc),
        .CR_PERDIO_JC_OUT (a_pjc),
        .CR_RANAS_OUT     (a_ranas),
        .CR_VIDAS_OUT     (a_vidas),
        .CR_TIMEOUT_OUT   (a_to)
    );

    control_ranas_n #(
        .NUM_RANAS      (2),
        .NUM_VIDAS      (2),
        .TIMEOUT_CICLOS (TO)
    ) u_b (
        .CR_CLOCK_50      (clk),
        .CR_RESET         (rst),
        .CR_ESTADO        (estado),
        .CR_GANO          (gano),
        .CR_PERDIO        (perdio),
        .CR_RANA_INI_OUT  (b_rana),
        .CR_GANO_JC_OUT   (b_gjc),
        .CR_PERDIO_JC_OUT (b_pjc),
        .CR_RANAS_OUT     (b_ranas),
        .CR_VIDAS_OUT     (b_vidas),
        .CR_TIMEOUT_OUT   (b_to)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One game step from the rules: start, place, play (win beats loss), finish.
    function automatic mdl_t step(input mdl_t s, input int nr, input int nv,
                                  input logic r, input logic [2:0] e,
                                  input logic g, input logic p);
        mdl_t n = s;
        bit   to;
        if (r) begin
            n = '{ph: 0, ranas: 0, vidas: nv, tmr: 0};
        end else begin
            case (s.ph)
                0: if (e == 3'b111) begin n.ph = 1; n.ranas = 0; n.vidas = nv; end
                1: begin n.ph = 2; n.tmr = 0; end
                2: begin
                    to = TO_EN && (s.tmr == TO - 1);
                    if (g) begin
                        n.ranas = s.ranas + 1;
                        n.ph    = (n.ranas == nr) ? 3 : 1;
                    end else if (p || to) begin
                        n.vidas = s.vidas - 1;
                        n.ph    = (n.vidas == 0) ? 4 : 1;
                    end else begin
                        n.tmr = s.tmr + 1;
                    end
                end
                default: n.ph = 0;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = step(m_a, 3, 1, rst, estado, gano, perdio);
        m_b = step(m_b, 2, 2, rst, estado, gano, perdio);
    end

    task automatic cmp(input string tag, input mdl_t s, input logic rana, input logic gjc,
                       input logic pjc, input logic [31:0] ranas, input logic [31:0] vidas,
                       input logic to);
        check({tag, ".rana_ini"}, rana, (s.ph == 1 || s.ph == 3 || s.ph == 4));
        check({tag, ".gano_jc"}, gjc, (s.ph == 3));
        check({tag, ".perdio_jc"}, pjc, (s.ph == 4));
        check({tag, ".ranas"}, ranas, s.ranas);
        check({tag, ".vidas"}, vidas, s.vidas);
        check({tag, ".timeout"}, to, TO_EN && s.ph == 2 && s.tmr == TO - 1 && !gano);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("A", m_a, a_rana, a_gjc, a_pjc, a_ranas, a_vidas, a_to);
            cmp("B", m_b, b_rana, b_gjc, b_pjc, b_ranas, b_vidas, b_to);
            c_rana_a += int'(a_rana);
            c_gjc_a  += int'(a_gjc);
            c_pjc_a  += int'(a_pjc);
            c_to_a   += int'(a_to);
            c_rana_b += int'(b_rana);
            c_pjc_b  += int'(b_pjc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        c_rana_a = 0; c_gjc_a = 0; c_pjc_a = 0; c_to_a = 0;
        c_rana_b = 0; c_pjc_b = 0;
    endtask

    task automatic start_game();
        estado = 3'b111;
        cyc();
        estado = 3'b000;
        cyc();
    endtask

    task automatic pulse(input logic g, input logic p);
        gano   = g;
        perdio = p;
        cyc();
        gano   = 1'b0;
        perdio = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; estado = 3'b000; gano = 1'b0; perdio = 1'b0;
        clr_cnt();
        repeat (2) cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        check("reset.a_ranas", a_ranas, 0);
        check("reset.a_vidas", a_vidas, 1);
        check("reset.b_vidas", b_vidas, 2);
        check("reset.a_rana_ini", a_rana, 0);

        // CR_GANO held while idle with a non-start code: nothing happens
        clr_cnt();
        gano = 1'b1; estado = 3'b010;
        repeat (5) cyc();
        gano = 1'b0; estado = 3'b000;
        cyc();
        check("idle_gano.rana_pulses", c_rana_a, 0);
        check("idle_gano.gano_pulses", c_gjc_a, 0);

        // Three frogs home on the default instance
        clr_cnt();
        start_game();
        repeat (3) pulse(1'b1, 1'b0);
        cyc();
        check("win.rana_pulses", c_rana_a, 4);
        check("win.gano_pulses", c_gjc_a, 1);
        check("win.ranas", a_ranas, 3);
        check("win.idle_after", a_rana, 0);

        // Two losses on the two-life instance
        clr_cnt();
        start_game();
        pulse(1'b0, 1'b1);
        check("lose1.b_vidas", b_vidas, 1);
        check("lose1.b_perdio_pulses", c_pjc_b, 0);
        pulse(1'b0, 1'b1);
        cyc();
        check("lose2.b_perdio_pulses", c_pjc_b, 1);
        check("lose2.b_vidas", b_vidas, 0);

        // Win and loss in the same cycle: win counts, loss discarded
        start_game();
        pulse(1'b1, 1'b1);
        check("both.a_ranas", a_ranas, 1);
        check("both.a_vidas", a_vidas, 1);
        pulse(1'b1, 1'b0);
        check("pre_reset.a_ranas", a_ranas, 2);

        // Reset in mid-game
        clr_cnt();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midreset.a_ranas", a_ranas, 0);
        check("midreset.a_vidas", a_vidas, 1);
        check("midreset.a_rana_ini", a_rana, 0);
        repeat (3) cyc();
        check("midreset.no_pulses", c_rana_a + c_gjc_a + c_pjc_a, 0);

`ifdef CR_TIMEOUT_EN
        // Frog left alone: timeout on its 10th playing cycle, then game lost
        clr_cnt();
        start_game();
        repeat (8) cyc();
        check("timeout.not_yet", c_to_a, 0);
        cyc();
        check("timeout.pulse_now", a_to, 1);
        repeat (2) cyc();
        check("timeout.count", c_to_a, 1);
        check("timeout.perdio_pulses", c_pjc_a, 1);
        check("timeout.b_vidas", b_vidas, 1);
`endif

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            estado = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            gano   = ($urandom_range(0, 5) == 0);
            perdio = ($urandom_range(0, 5) == 0);
            cyc();
        end
        rst = 1'b0; gano = 1'b0; perdio = 1'b0; estado = 3'b000;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_ranas_n.md
CONTROL_RANAS_N -- requirements
Module: control_ranas_n

Interface
REQ-001 SHALL have parameter DATAWIDTH_ESTADO, default 3, width of CR_ESTADO.
REQ-002 SHALL have parameter START_CODE, default 3'b111, CR_ESTADO value that starts a game.
REQ-003 SHALL have parameter NUM_RANAS, default 3, frogs that must reach home to win (>=1).
REQ-004 SHALL have parameter NUM_VIDAS, default 1, lives per game (>=1).
REQ-005 SHALL have parameter TIMEOUT_CICLOS, default 50000000, cycles allowed per frog (timeout feature only).
REQ-006 SHALL have derived widths RW=$clog2(NUM_RANAS+1) and VW=$clog2(NUM_VIDAS+1).
REQ-007 SHALL have port CR_CLOCK_50  input  1  single system clock, rising edge.
REQ-008 SHALL have port CR_RESET  input  1  synchronous, active-high reset.
REQ-009 SHALL have port CR_ESTADO  input  DATAWIDTH_ESTADO  game state code from the top-level controller.
REQ-010 SHALL have port CR_GANO  input  1  current frog reached home (level, sampled each cycle).
REQ-011 SHALL have port CR_PERDIO  input  1  current frog died (level, sampled each cycle).
REQ-012 SHALL have port CR_RANA_INI_OUT  output  1  one-cycle pulse that places a new frog at the start position.
REQ-013 SHALL have port CR_GANO_JC_OUT  output  1  one-cycle game-won pulse.
REQ-014 SHALL have port CR_PERDIO_JC_OUT  output  1  one-cycle game-lost pulse.
REQ-015 SHALL have port CR_RANAS_OUT  output  RW  number of frogs home in the current game.
REQ-016 SHALL have port CR_VIDAS_OUT  output  VW  number of lives remaining.
REQ-017 SHALL have port CR_TIMEOUT_OUT  output  1  one-cycle pulse when a frog times out.

Function
REQ-018 SHALL implement states INICIO, INI_RANA, JUGANDO, GANO, PERDIO; 1-hot outputs SHALL be decoded from the state register only (Moore).
REQ-019 SHALL, in INICIO with CR_ESTADO==START_CODE, go to INI_RANA and load RANAS=0 and VIDAS=NUM_VIDAS; otherwise hold.
REQ-020 SHALL assert CR_RANA_INI_OUT=1 in INI_RANA for exactly one cycle, then go to JUGANDO.
REQ-021 SHALL, in JUGANDO with CR_GANO=1, increment RANAS and go to GANO if the new count equals NUM_RANAS, else to INI_RANA.
REQ-022 SHALL, in JUGANDO with CR_GANO=0 and a loss event (CR_PERDIO=1, or timeout), decrement VIDAS and go to PERDIO if the new count is 0, else to INI_RANA.
REQ-023 SHALL give CR_GANO priority when CR_GANO and a loss event occur in the same cycle; the loss SHALL be discarded.
REQ-024 SHALL hold in JUGANDO when no event occurs; CR_GANO/CR_PERDIO SHALL be ignored in all states other than JUGANDO.
REQ-025 SHALL drive CR_GANO_JC_OUT=1 and CR_RANA_INI_OUT=1 for one cycle in GANO, then go to INICIO.
REQ-026 SHALL drive CR_PERDIO_JC_OUT=1 and CR_RANA_INI_OUT=1 for one cycle in PERDIO, then go to INICIO.
REQ-027 SHALL keep CR_RANAS_OUT and CR_VIDAS_OUT unchanged in INICIO, so that end-of-game values stay visible until the next start.
REQ-028 SHALL decode any unused state encoding as INICIO, with all pulse outputs 0.

Reset
REQ-029 SHALL, when CR_RESET=1 at a clock edge, set state to INICIO, RANAS=0, VIDAS=NUM_VIDAS, timer=0, and all pulse outputs to 0, including during an active game.
REQ-030 SHALL have reset priority over every other input.

Configuration
REQ-031 SHALL, with macro CR_TIMEOUT_EN defined, count cycles in JUGANDO, clear the count in INI_RANA, and when the count reaches TIMEOUT_CICLOS-1 without CR_GANO, pulse CR_TIMEOUT_OUT for that cycle and treat it as a loss event.
REQ-032 SHALL, without CR_TIMEOUT_EN, contain no timer logic and tie CR_TIMEOUT_OUT to 0.

Structure
REQ-033 SHALL take state encodings (4-bit, INICIO=0) from the shared package control_ranas_pkg, which also holds the default START_CODE.
REQ-034 SHALL place the timeout counter in sub-module control_ranas_timer (inputs: clear, enable; output: expire), instantiated only under CR_TIMEOUT_EN.

Verification
REQ-035 SHALL cover: defaults; CR_ESTADO=3'b111; three CR_GANO pulses, each in JUGANDO -> RANA_INI pulses 4 times, GANO_JC pulse once, RANAS_OUT=3, then INICIO.
REQ-036 SHALL cover: NUM_VIDAS=2; start; CR_PERDIO, then CR_PERDIO -> first loss gives INI_RANA with VIDAS_OUT=1, second gives PERDIO_JC pulse with VIDAS_OUT=0.
REQ-037 SHALL cover: CR_GANO=1 and CR_PERDIO=1 in the same JUGANDO cycle -> RANAS_OUT +1, VIDAS_OUT unchanged.
REQ-038 SHALL cover: CR_RESET=1 for one cycle with RANAS_OUT=2 -> next cycle state INICIO, RANAS_OUT=0, VIDAS_OUT=NUM_VIDAS, no pulses.
REQ-039 SHALL cover: CR_TIMEOUT_EN with TIMEOUT_CICLOS=10 and no CR_GANO -> TIMEOUT_OUT pulse on the 10th JUGANDO cycle, then PERDIO_JC pulse (NUM_VIDAS=1).
REQ-040 SHALL cover: CR_GANO held high while in INICIO, with CR_ESTADO not equal to START_CODE -> no state change and no pulses.
